// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of chunk cycles per operation.
    function automatic int unsigned calc_n(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; at least one bit even when a single chunk covers the word.
    function automatic int unsigned calc_cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, x, y, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, x, y, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/chunk_subtractor.sv
// Combinational ripple of CHUNK full-subtractor cells, LSB first.
module chunk_subtractor #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             br_in,
    output logic [CHUNK-1:0] diff,
    output logic             br_out
);

    logic br;

    always_comb begin
        diff = '0;
        br   = br_in;
        for (int i = 0; i < int'(CHUNK); i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        br_out = br;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle D = X - Y - Bin, CHUNK bits per clock with a registered borrow chain.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic clk,
    input  logic rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned N     = calc_n(WIDTH, CHUNK);
    localparam int unsigned CNT_W = calc_cnt_w(N);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             br_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept_c;
    logic             run_c;
    logic             last_c;
    logic [31:0]      base_c;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] diff_c;
    logic             br_out_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        run_c    = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                run_c = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    last_c  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single chunk cell, steered by the chunk counter
    assign base_c = 32'(cnt_q) * 32'(CHUNK);
    assign a_c    = x_q[base_c +: CHUNK];
    assign b_c    = y_q[base_c +: CHUNK];

    chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
        .a      (a_c),
        .b      (b_c),
        .br_in  (br_q),
        .diff   (diff_c),
        .br_out (br_out_c)
    );

    // Operand, borrow, result and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            br_q        <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (accept_c) begin
                x_q   <= bus.x;
                y_q   <= bus.y;
                br_q  <= bus.bin;
                cnt_q <= '0;
            end else if (run_c) begin
                d_q[base_c +: CHUNK] <= diff_c;
                br_q                 <= br_out_c;
                cnt_q                <= cnt_q + CNT_W'(1);
                if (last_c) begin
                    bout_q <= br_out_c;
                    // The final chunk carries the result sign bit.
                    ovf_q  <= (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                              (diff_c[CHUNK-1] != x_q[WIDTH-1]);
                end
            end
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;

endmodule
